// File: rtl/lc3_ctrl_seq_if.sv
// rtl/lc3_ctrl_seq_if.sv - IR/BEN inputs and datapath/SRAM control outputs of the LC-3 sequencer
interface lc3_ctrl_seq_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/lc3_ctrl_seq.sv
// rtl/lc3_ctrl_seq.sv - LC-3 control sequencer with parameterised SRAM strobe length
module lc3_ctrl_seq #(
    parameter int MEM_WAIT = 2,
    parameter bit PAUSE_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    lc3_ctrl_seq_if.master   bus
);
    typedef enum logic [4:0] {
        HALTED, F_MAR, F_RD, F_IR, DECODE,
        S_ADD, S_AND, S_NOT, S_LEA,
        A_PC9, A_R6, M_RD, IND, WB, ST_DATA, M_WR,
        J_R7, J_PC, S_JMP, BR_CHK, BR_TAKE, P1, P2
    } state_t;

    localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       ind, ind_nx, st, st_nx;
    logic       last;

    assign last       = (cnt == LAST);
    assign bus.Mem_CE = 1'b0;
    assign bus.Mem_UB = 1'b0;
    assign bus.Mem_LB = 1'b0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= HALTED;
            cnt   <= 4'd0;
            ind   <= 1'b0;
            st    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ind   <= ind_nx;
            st    <= st_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = 4'd0;
        ind_nx         = ind;
        st_nx          = st;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;

        case (state)
            HALTED: if (bus.Run) state_nx = F_MAR;
            F_MAR: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                state_nx   = F_RD;
            end
            // cnt_nx defaults to 0, so the counter clears on every strobe exit
            F_RD: begin
                bus.Mem_OE = 1'b0;
                if (last) begin
                    bus.LD_MDR = 1'b1;
                    state_nx   = F_IR;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            F_IR: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                state_nx    = DECODE;
            end
            DECODE: begin
                bus.LD_BEN = 1'b1;
                case (bus.Opcode)
                    4'b0001: state_nx = S_ADD;
                    4'b0101: state_nx = S_AND;
                    4'b1001: state_nx = S_NOT;
                    4'b1110: state_nx = S_LEA;
                    4'b0010: state_nx = A_PC9;
                    4'b1010: begin state_nx = A_PC9; ind_nx = 1'b1; end
                    4'b0011: begin state_nx = A_PC9; st_nx = 1'b1; end
                    4'b1011: begin state_nx = A_PC9; ind_nx = 1'b1; st_nx = 1'b1; end
                    4'b0110: state_nx = A_R6;
                    4'b0111: begin state_nx = A_R6; st_nx = 1'b1; end
                    4'b0100: state_nx = J_R7;
                    4'b1100: state_nx = S_JMP;
                    4'b0000: state_nx = BR_CHK;
                    4'b1101: state_nx = PAUSE_EN ? P1 : F_MAR;
                    default: state_nx = F_MAR;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                bus.ALUK    = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
                bus.SR2MUX  = (state != S_NOT) && bus.IR_5;
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                state_nx    = F_MAR;
            end
            S_LEA: begin
                bus.ADDR2MUX   = 2'b10;
                bus.GateMARMUX = 1'b1;
                bus.LD_REG     = 1'b1;
                bus.LD_CC      = 1'b1;
                state_nx       = F_MAR;
            end
            // Only direct stores skip the read; STI reads its pointer first
            A_PC9, A_R6: begin
                bus.ADDR1MUX   = (state == A_R6);
                bus.ADDR2MUX   = (state == A_R6) ? 2'b01 : 2'b10;
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                state_nx       = (st && !ind) ? ST_DATA : M_RD;
            end
            M_RD: begin
                bus.Mem_OE = 1'b0;
                if (last) begin
                    bus.LD_MDR = 1'b1;
                    state_nx   = ind ? IND : WB;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            IND: begin
                bus.GateMDR = 1'b1;
                bus.LD_MAR  = 1'b1;
                ind_nx      = 1'b0;
                state_nx    = st ? ST_DATA : M_RD;
            end
            WB: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                state_nx    = F_MAR;
            end
            ST_DATA: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                state_nx    = M_WR;
            end
            M_WR: begin
                bus.Mem_WE = 1'b0;
                if (last) begin
                    st_nx    = 1'b0;
                    state_nx = F_MAR;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            J_R7: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
                state_nx   = J_PC;
            end
            J_PC: begin
                bus.ADDR1MUX = !bus.IR_11;
                bus.ADDR2MUX = bus.IR_11 ? 2'b11 : 2'b00;
                bus.PCMUX    = 2'b01;
                bus.LD_PC    = 1'b1;
                state_nx     = F_MAR;
            end
            S_JMP: begin
                bus.ADDR1MUX = 1'b1;
                bus.PCMUX    = 2'b01;
                bus.LD_PC    = 1'b1;
                state_nx     = F_MAR;
            end
            BR_CHK: state_nx = bus.BEN ? BR_TAKE : F_MAR;
            BR_TAKE: begin
                bus.ADDR2MUX = 2'b10;
                bus.PCMUX    = 2'b01;
                bus.LD_PC    = 1'b1;
                state_nx     = F_MAR;
            end
            P1: begin
                bus.LD_LED = 1'b1;
                if (bus.Continue) state_nx = P2;
            end
            P2: if (!bus.Continue) state_nx = F_MAR;
            default: state_nx = HALTED;
        endcase
    end
endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// tb/tb_lc3_ctrl_seq.sv - self-checking bench for lc3_ctrl_seq at MEM_WAIT 2, 3 and 1
module tb_lc3_ctrl_seq;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [2:0] run_v = 3'b000;
    logic       cont = 1'b0, ir5 = 1'b0, ir11 = 1'b0, ben = 1'b0;
    logic [3:0] opc = 4'b1000;

    lc3_ctrl_seq_if bus_a ();
    lc3_ctrl_seq_if bus_b ();
    lc3_ctrl_seq_if bus_c ();

    lc3_ctrl_seq #(.MEM_WAIT(2), .PAUSE_EN(1'b1)) dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
    lc3_ctrl_seq #(.MEM_WAIT(3), .PAUSE_EN(1'b0)) dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));
    lc3_ctrl_seq #(.MEM_WAIT(1), .PAUSE_EN(1'b1)) dut_c (.Clk(Clk), .Reset(Reset), .bus(bus_c));

    assign bus_a.Run = run_v[0];  assign bus_b.Run = run_v[1];  assign bus_c.Run = run_v[2];
    assign bus_a.Continue = cont; assign bus_b.Continue = cont; assign bus_c.Continue = cont;
    assign bus_a.Opcode = opc;    assign bus_b.Opcode = opc;    assign bus_c.Opcode = opc;
    assign bus_a.IR_5 = ir5;      assign bus_b.IR_5 = ir5;      assign bus_c.IR_5 = ir5;
    assign bus_a.IR_11 = ir11;    assign bus_b.IR_11 = ir11;    assign bus_c.IR_11 = ir11;
    assign bus_a.BEN = ben;       assign bus_b.BEN = ben;       assign bus_c.BEN = ben;

    typedef struct packed {
        logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
        logic GatePC, GateMDR, GateALU, GateMARMUX;
        logic [1:0] PCMUX;
        logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
        logic [1:0] ADDR2MUX;
        logic [1:0] ALUK;
        logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    } outs_t;

    outs_t o_a, o_b, o_c, cur;
    int sel = 0;
    assign o_a = {bus_a.LD_MAR, bus_a.LD_MDR, bus_a.LD_IR, bus_a.LD_BEN, bus_a.LD_CC, bus_a.LD_REG, bus_a.LD_PC, bus_a.LD_LED,
                  bus_a.GatePC, bus_a.GateMDR, bus_a.GateALU, bus_a.GateMARMUX, bus_a.PCMUX, bus_a.DRMUX, bus_a.SR1MUX,
                  bus_a.SR2MUX, bus_a.ADDR1MUX, bus_a.ADDR2MUX, bus_a.ALUK, bus_a.Mem_CE, bus_a.Mem_UB, bus_a.Mem_LB, bus_a.Mem_OE, bus_a.Mem_WE};
    assign o_b = {bus_b.LD_MAR, bus_b.LD_MDR, bus_b.LD_IR, bus_b.LD_BEN, bus_b.LD_CC, bus_b.LD_REG, bus_b.LD_PC, bus_b.LD_LED,
                  bus_b.GatePC, bus_b.GateMDR, bus_b.GateALU, bus_b.GateMARMUX, bus_b.PCMUX, bus_b.DRMUX, bus_b.SR1MUX,
                  bus_b.SR2MUX, bus_b.ADDR1MUX, bus_b.ADDR2MUX, bus_b.ALUK, bus_b.Mem_CE, bus_b.Mem_UB, bus_b.Mem_LB, bus_b.Mem_OE, bus_b.Mem_WE};
    assign o_c = {bus_c.LD_MAR, bus_c.LD_MDR, bus_c.LD_IR, bus_c.LD_BEN, bus_c.LD_CC, bus_c.LD_REG, bus_c.LD_PC, bus_c.LD_LED,
                  bus_c.GatePC, bus_c.GateMDR, bus_c.GateALU, bus_c.GateMARMUX, bus_c.PCMUX, bus_c.DRMUX, bus_c.SR1MUX,
                  bus_c.SR2MUX, bus_c.ADDR1MUX, bus_c.ADDR2MUX, bus_c.ALUK, bus_c.Mem_CE, bus_c.Mem_UB, bus_c.Mem_LB, bus_c.Mem_OE, bus_c.Mem_WE};

    always_comb begin
        case (sel)
            1:       cur = o_b;
            2:       cur = o_c;
            default: cur = o_a;
        endcase
    end

    localparam logic [15:0] M_MAR = 16'h0001, M_REG = 16'h0002, M_CC = 16'h0004, M_PC = 16'h0008;
    localparam logic [15:0] M_GPC = 16'h0010, M_GALU = 16'h0020, M_GMM = 16'h0040, M_WE = 16'h0080;
    localparam logic [15:0] M_LED = 16'h0100, M_DR = 16'h0200, M_SR2 = 16'h0400, M_A1 = 16'h0800;
    localparam logic [15:0] M_A2_01 = 16'h1000, M_A2_10 = 16'h2000, M_AL_01 = 16'h4000, M_AL_10 = 16'h8000;
    localparam logic [26:0] IDLE = 27'd3;

    typedef struct {
        logic [3:0]  op;
        logic        ir5, ir11, ben;
        logic [15:0] mask;
        int          rd, wr, k;
        string       name;
    } row_t;

    typedef struct {
        string       name;
        int          lat, oe, we;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic fmar(outs_t o);
        return o.GatePC && o.LD_MAR && o.LD_PC;
    endfunction

    function automatic logic [15:0] sig(outs_t o);
        return {o.ALUK, o.ADDR2MUX, o.ADDR1MUX, o.SR2MUX, o.DRMUX, o.LD_LED, ~o.Mem_WE,
                o.GateMARMUX, o.GateALU, o.GatePC, o.LD_PC, o.LD_CC, o.LD_REG, o.LD_MAR};
    endfunction

    task automatic start(int s);
        int c = 0;
        sel = s;
        run_v[s] = 1'b1;
        @(negedge Clk);
        run_v = 3'b000;
        while (!fmar(cur) && c < 50) begin
            @(negedge Clk);
            c++;
        end
        check($sformatf("start%0d_fmar", s), fmar(cur), 1);
    endtask

    // Called at a sample point where cur shows F_MAR; returns at the next F_MAR.
    task automatic run_row(row_t r, int w);
        exp_t e;
        int lat, oe, we, both;
        logic [15:0] acc;
        logic done;
        opc = r.op; ir5 = r.ir5; ir11 = r.ir11; ben = r.ben;
        e.name = r.name;
        e.lat  = (r.rd + r.wr) * w + r.k;
        e.oe   = r.rd * w;
        e.we   = r.wr * w;
        e.mask = r.mask;
        sb.push_back(e);
        lat = 1; oe = 0; we = 0; both = 0; acc = '0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge Clk);
            if (fmar(cur)) done = 1'b1;
            else begin
                lat++;
                if (!cur.Mem_OE) oe++;
                if (!cur.Mem_WE) we++;
                if (!cur.Mem_OE && !cur.Mem_WE) both++;
                acc |= sig(cur);
            end
        end
        e = sb.pop_front();
        check($sformatf("%s_return", e.name), done, 1);
        check($sformatf("%s_latency", e.name), lat, e.lat);
        check($sformatf("%s_signals", e.name), acc, e.mask);
        check($sformatf("%s_oe_cycles", e.name), oe, e.oe);
        check($sformatf("%s_we_cycles", e.name), we, e.we);
        check($sformatf("%s_oe_we_overlap", e.name), both, 0);
    endtask

    row_t rows[18];
    row_t r_ldi, r_sti, r_nop1101;

    initial begin
        rows[0]  = '{4'b0001, 1'b1, 1'b0, 1'b0, M_SR2 | M_GALU | M_REG | M_CC, 1, 0, 4, "add_imm"};
        rows[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, M_GALU | M_REG | M_CC, 1, 0, 4, "add_reg"};
        rows[2]  = '{4'b0101, 1'b1, 1'b0, 1'b0, M_AL_01 | M_SR2 | M_GALU | M_REG | M_CC, 1, 0, 4, "and_imm"};
        rows[3]  = '{4'b1001, 1'b1, 1'b0, 1'b0, M_AL_10 | M_GALU | M_REG | M_CC, 1, 0, 4, "not"};
        rows[4]  = '{4'b1110, 1'b0, 1'b0, 1'b0, M_A2_10 | M_GMM | M_REG | M_CC, 1, 0, 4, "lea"};
        rows[5]  = '{4'b1100, 1'b0, 1'b0, 1'b0, M_A1 | M_PC, 1, 0, 4, "jmp"};
        rows[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, 4, "br_not_taken"};
        rows[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, M_A2_10 | M_PC, 1, 0, 5, "br_taken"};
        rows[8]  = '{4'b0100, 1'b0, 1'b1, 1'b0, M_GPC | M_DR | M_REG | M_A2_01 | M_A2_10 | M_PC, 1, 0, 5, "jsr"};
        rows[9]  = '{4'b0100, 1'b0, 1'b0, 1'b0, M_GPC | M_DR | M_REG | M_A1 | M_PC, 1, 0, 5, "jsrr"};
        rows[10] = '{4'b0010, 1'b0, 1'b0, 1'b0, M_GMM | M_MAR | M_A2_10 | M_REG | M_CC, 2, 0, 5, "ld"};
        rows[11] = '{4'b0110, 1'b0, 1'b0, 1'b0, M_GMM | M_MAR | M_A1 | M_A2_01 | M_REG | M_CC, 2, 0, 5, "ldr"};
        rows[12] = '{4'b1010, 1'b0, 1'b0, 1'b0, M_GMM | M_MAR | M_A2_10 | M_REG | M_CC, 3, 0, 6, "ldi"};
        rows[13] = '{4'b0011, 1'b0, 1'b0, 1'b0, M_GMM | M_MAR | M_A2_10 | M_AL_01 | M_AL_10 | M_GALU | M_WE, 1, 1, 5, "st"};
        rows[14] = '{4'b0111, 1'b0, 1'b0, 1'b0, M_GMM | M_MAR | M_A1 | M_A2_01 | M_AL_01 | M_AL_10 | M_GALU | M_WE, 1, 1, 5, "str"};
        rows[15] = '{4'b1011, 1'b0, 1'b0, 1'b0, M_GMM | M_MAR | M_A2_10 | M_AL_01 | M_AL_10 | M_GALU | M_WE, 2, 1, 6, "sti"};
        rows[16] = '{4'b1000, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, 3, "nop_1000"};
        rows[17] = '{4'b1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, 3, "nop_1111"};
        r_ldi     = rows[12];
        r_sti     = rows[15];
        r_nop1101 = '{4'b1101, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, 3, "nop_1101"};

        // Reset state of all three instances
        repeat (3) @(negedge Clk);
        check("reset_a", o_a, IDLE);
        check("reset_b", o_b, IDLE);
        check("reset_c", o_c, IDLE);
        Reset = 1'b0;
        @(negedge Clk);
        check("halted_idle", o_a, IDLE);

        // Fetch timing at MEM_WAIT=2, opcode 1000 as a NOP
        sel = 0;
        opc = 4'b1000;
        run_v[0] = 1'b1;
        @(negedge Clk);
        run_v = 3'b000;
        check("fetch_fmar", {fmar(cur), cur.PCMUX}, 3'b100);
        @(negedge Clk);
        check("fetch_rd0", {cur.Mem_OE, cur.LD_MDR}, 2'b00);
        @(negedge Clk);
        check("fetch_rd1", {cur.Mem_OE, cur.LD_MDR}, 2'b01);
        @(negedge Clk);
        check("fetch_ir", {cur.Mem_OE, cur.GateMDR, cur.LD_IR}, 3'b111);
        @(negedge Clk);
        check("decode_ben", {cur.LD_BEN, cur.Mem_OE}, 2'b11);
        @(negedge Clk);
        check("nop_back_to_fmar", fmar(cur), 1);

        // Table at MEM_WAIT=2 with Run held high to show it is ignored
        run_v[0] = 1'b1;
        for (int i = 0; i < 18; i++) run_row(rows[i], 2);
        run_v = 3'b000;

        // PAUSE handshake: Continue 0 -> 1 -> 0
        opc = 4'b1101;
        cont = 1'b0;
        repeat (5) @(negedge Clk);
        check("p1_led", cur.LD_LED, 1);
        repeat (2) @(negedge Clk);
        check("p1_led_held", {cur.LD_LED, fmar(cur)}, 2'b10);
        cont = 1'b1;
        @(negedge Clk);
        check("p2_enter", {cur.LD_LED, fmar(cur)}, 2'b00);
        @(negedge Clk);
        check("p2_hold", fmar(cur), 0);
        cont = 1'b0;
        @(negedge Clk);
        check("p2_exit", fmar(cur), 1);

        // Reset during the first M_WR cycle of an ST
        opc = 4'b0011;
        repeat (7) @(negedge Clk);
        check("st_mwr_strobe", cur.Mem_WE, 0);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_mid_mwr", o_a, IDLE);
        Reset = 1'b0;
        @(negedge Clk);
        check("halted_after_reset", o_a, IDLE);
        start(0);
        run_row(r_ldi, 2);

        // MEM_WAIT=3 with PAUSE disabled
        start(1);
        run_row(r_ldi, 3);
        run_row(r_nop1101, 3);

        // MEM_WAIT=1: STI then LDI shows both flags were cleared
        start(2);
        run_row(r_sti, 1);
        run_row(r_ldi, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lc3_ctrl_seq.md
# lc3_ctrl_seq

Parametrised control sequencer for the LC-3 datapath, the successor to the fixed-latency lab ISDU. It decodes the full memory/control subset: ADD, AND, NOT, LEA, LD, LDR, LDI, ST, STR, STI, BR, JMP/RET, JSR/JSRR and PAUSE. SRAM read and write strobes are held for a parameterised number of cycles by an internal wait counter. It sits between the IR/BEN logic and the datapath muxes, gates and load enables, and drives the SRAM control pins.

## Interface
- MEM_WAIT, 2, cycles each SRAM read/write strobe is held; legal range 1..15.
- PAUSE_EN, 1, 1 = opcode 1101 is PAUSE (LED load plus Continue handshake); 0 = 1101 is a NOP.
- Reset: synchronous, active-high, signal `Reset`. Clock: `Clk`.
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- Run, Continue  in  1  start pulse; pause-release handshake
- Opcode  in  4  IR[15:12]
- IR_5, IR_11  in  1  immediate select; JSR/JSRR select
- BEN  in  1  branch-enable (registered by datapath on LD_BEN)
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1  bus drivers, at most one high per cycle
- PCMUX  out  2  00 PC+1, 01 address adder, 10 bus
- DRMUX  out  1  0 IR[11:9], 1 R7
- SR1MUX  out  1  0 IR[8:6], 1 IR[11:9]
- SR2MUX  out  1  0 register, 1 imm5
- ADDR1MUX  out  1  0 PC, 1 SR1
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1  SRAM controls, active-low

## Operation
- **Default outputs:** every output not listed for a state is 0, except Mem_OE=Mem_WE=1. Mem_CE, Mem_UB and Mem_LB are tied to 0.
- **Registers:** state, wait counter `cnt` (4 bits), flags `ind` and `st`.
- **Reset values:** state=HALTED, cnt=0, ind=st=0. All outputs at their defaults.
- **Fetch path:**
  - HALTED: Run=1 → F_MAR.
  - F_MAR: GatePC, LD_MAR, LD_PC, PCMUX=00 → F_RD.
  - F_RD: Mem_OE=0; LD_MDR when cnt=MEM_WAIT-1, then → F_IR.
  - F_IR: GateMDR, LD_IR → DECODE.
  - DECODE: LD_BEN; dispatch on Opcode.
- **ALU ops** (each then → F_MAR):
  - ADD (0001): ALUK=00, SR2MUX=IR_5, GateALU, LD_REG, LD_CC.
  - AND (0101): ALUK=01, SR2MUX=IR_5, GateALU, LD_REG, LD_CC.
  - NOT (1001): ALUK=10, GateALU, LD_REG, LD_CC.
  - LEA (1110): ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_REG, LD_CC.
- **Address states** (each asserts GateMARMUX and LD_MAR):
  - LD (0010) and LDI (1010): ADDR1MUX=0, ADDR2MUX=10.
  - LDR (0110): ADDR1MUX=1, SR1MUX=0, ADDR2MUX=01.
  - ST (0011) and STI (1011): same addressing as LD.
  - STR (0111): same addressing as LDR.
  - Flags set on entry: ind=1 for LDI/STI; st=1 for ST/STR/STI.
- **Routing after the address state:**
  - LD/LDR/LDI/STI → M_RD.
  - ST/STR → ST_DATA.
- **M_RD:** Mem_OE=0 for MEM_WAIT cycles; LD_MDR on the last cycle. Exit to IND if ind=1, else WB.
- **IND:** GateMDR, LD_MAR; clear ind. Exit to ST_DATA if st=1, else M_RD.
- **WB:** GateMDR, LD_REG, LD_CC → F_MAR.
- **ST_DATA:** SR1MUX=1, ALUK=11, GateALU, LD_MDR → M_WR.
- **M_WR:** Mem_WE=0 for MEM_WAIT cycles; then clear st → F_MAR.
- **JSR (0100):**
  - J_R7: GatePC, DRMUX=1, LD_REG → J_PC.
  - J_PC, IR_11=1: ADDR1MUX=0, ADDR2MUX=11.
  - J_PC, IR_11=0: ADDR1MUX=1, SR1MUX=0, ADDR2MUX=00.
  - Both cases: PCMUX=01, LD_PC → F_MAR.
  - JSRR with BaseR=R7 jumps to the old PC+1. This is a documented limitation.
- **JMP (1100):** ADDR1MUX=1, SR1MUX=0, ADDR2MUX=00, PCMUX=01, LD_PC → F_MAR.
- **BR (0000):**
  - BR_CHK: BEN=0 → F_MAR; BEN=1 → BR_TAKE.
  - BR_TAKE: ADDR1MUX=0, ADDR2MUX=10, PCMUX=01, LD_PC → F_MAR.
- **PAUSE (1101, PAUSE_EN=1):**
  - P1: LD_LED=1 every cycle; stay until Continue=1, then → P2.
  - P2: stay while Continue=1; Continue=0 → F_MAR.
- **Other opcodes:** 1000, 1111, 1101 with PAUSE_EN=0, and any unused opcode → F_MAR (NOP).

## Timing
- cnt increments in F_RD, M_RD and M_WR, and clears to 0 on leaving any of them. It never exceeds MEM_WAIT-1.
- Fetch-plus-decode takes MEM_WAIT+3 cycles (F_MAR to DECODE inclusive).
- Per-instruction latency including fetch:
  - ADD/AND/NOT/LEA/JMP: MEM_WAIT+4.
  - BR not taken: MEM_WAIT+4. BR taken: MEM_WAIT+5.
  - JSR: MEM_WAIT+5.
  - LD/LDR: 2·MEM_WAIT+5.
  - ST/STR: 2·MEM_WAIT+5.
  - LDI: 3·MEM_WAIT+6.
  - STI: 3·MEM_WAIT+6.
- Reset has priority in every state, including mid-strobe. On the next edge: state=HALTED, cnt=0, flags cleared, Mem_OE=Mem_WE=1 in the same cycle.
- Run is ignored outside HALTED. Continue is ignored outside P1/P2.
- Mem_OE and Mem_WE are never low in the same cycle.

## Test plan
- **Fetch timing (MEM_WAIT=2):** Reset, then Run pulse → F_MAR. Mem_OE low exactly 2 cycles; LD_MDR only on the second; LD_IR one cycle later.
- **LDI (MEM_WAIT=3), Opcode=1010:** two Mem_OE=0 bursts of 3 cycles each, separated by one cycle of IND (GateMDR+LD_MAR). WB asserts LD_REG and LD_CC. Total 15 cycles.
- **STI (MEM_WAIT=1):** read burst, IND, ST_DATA (ALUK=11, LD_MDR), then one cycle Mem_WE=0. Return to F_MAR; st and ind both 0.
- **BR:** BEN=0 → F_MAR directly after BR_CHK. BEN=1 → BR_TAKE with PCMUX=01, ADDR2MUX=10, LD_PC=1.
- **JSR/JSRR:** IR_11=1 → J_R7 (DRMUX=1), then ADDR2MUX=11. IR_11=0 → ADDR1MUX=1, ADDR2MUX=00.
- **Reset mid-M_WR, plus PAUSE:** Reset asserted in the first M_WR cycle → next cycle HALTED, Mem_WE=1. PAUSE with Continue 0→1→0 → LD_LED held through P1, then F_MAR. Repeat with PAUSE_EN=0 → 1101 goes directly to F_MAR.
